mock_uart_tx: RTL

Simulation-side UART transmitter that drives the SoC's `uart_rx` pin in the top-level testbench, replacing the constant-zero tie-off. It accepts bytes from the bench through a valid/ready write port and buffers them in a FIFO. It then serializes them as standard asynchronous frames at a fixed baud rate. It is the counterpart of `mock_uart_rx` and takes the same parameter set.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/mock_uart_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART mock package: parity modes, TX FSM states, and the bit-timing helper.
// No ports. Imported by mock_uart_tx, sync_fifo users and mock_uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  function automatic int clks_per_bit(
    input longint clk_hz,
    input longint baud
  );
    return int'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; async active-high reset clears pointers.
// Ports: clk, rst, i_push/i_data (write), i_pop/o_data (head read), o_count, o_full, o_empty.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [Width-1:0]             i_data,
  input  logic                         i_pop,
  output logic [Width-1:0]             o_data,
  output logic [$clog2(Depth+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = (Depth > 2) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);
  localparam logic [AW-1:0] LastPtr = AW'(Depth - 1);
  localparam logic [CW-1:0] FullCnt = CW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // No push-through when full, even with a pop in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= f_inc(r_wr);
      if (w_pop)  r_rd <= f_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/mock_uart_tx.sv
// Bench-side UART transmitter: FIFO-buffered bytes serialized as async frames.
// Ports: clk, rst, wr_valid/wr_ready/wr_data, tx_sig, busy, count. Macro: MOCK_UART_TX_TRACE_EN.
`ifndef CLK_FREQ
`define CLK_FREQ 100000000
`endif

module mock_uart_tx import uart_pkg::*; #(
  parameter int BaudRate     = 9600,
  parameter int ParityBit    = 0,
  parameter int DataBitsSize = 8,
  parameter int StopBitsSize = 1,
  parameter int BufferSize   = 128,
  parameter int ClockFreqHz  = `CLK_FREQ
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [DataBitsSize-1:0]             wr_data,
  output logic                                tx_sig,
  output logic                                busy,
  output logic [$clog2(BufferSize+1)-1:0]     count
);

  localparam int CPB = clks_per_bit(ClockFreqHz, BaudRate);
  localparam int BCW = (CPB > 2) ? $clog2(CPB) : 1;
  localparam parity_e Par = parity_e'(ParityBit);
  localparam logic [BCW-1:0] LastTick = BCW'(CPB - 1);
  localparam logic [3:0] LastData = 4'(DataBitsSize - 1);
  localparam logic [3:0] LastStop = 4'(StopBitsSize - 1);

  if (CPB < 2) begin : g_cpb_chk
    $error("mock_uart_tx: ClksPerBit must be >= 2");
  end
  if (DataBitsSize < 5 || DataBitsSize > 9) begin : g_dbs_chk
    $error("mock_uart_tx: DataBitsSize must be 5..9");
  end
  if (StopBitsSize < 1 || StopBitsSize > 2) begin : g_sbs_chk
    $error("mock_uart_tx: StopBitsSize must be 1 or 2");
  end
  if (BufferSize < 2) begin : g_buf_chk
    $error("mock_uart_tx: BufferSize must be >= 2");
  end

  uart_tx_state_e         r_state;
  uart_tx_state_e         w_state_nxt;
  logic [BCW-1:0]         r_tick_cnt;
  logic [3:0]             r_idx;
  logic [3:0]             w_idx_nxt;
  logic [DataBitsSize-1:0] r_shift;
  logic [DataBitsSize-1:0] w_shift_nxt;
  logic [DataBitsSize-1:0] w_head;
  logic                   r_par;
  logic                   r_tx;
  logic                   w_tx_nxt;
  logic                   w_tick;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  sync_fifo #(
    .Width (DataBitsSize),
    .Depth (BufferSize)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_valid),
    .i_data  (wr_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_tick   = (r_tick_cnt == LastTick);
  assign wr_ready = !w_fifo_full;
  assign busy     = (r_state != IDLE) || (count != '0);
  assign tx_sig   = r_tx;

  // State register; tx line is registered from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (r_state == IDLE || w_tick) r_tick_cnt <= '0;
      else                           r_tick_cnt <= r_tick_cnt + 1'b1;
      if (w_pop) r_par <= (Par == PARITY_ODD) ? ~^w_head : ^w_head;
    end
  end

  // Next-state decode; the stop-to-start path avoids any idle gap.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = START;
          w_pop       = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == LastData) begin
            w_idx_nxt = '0;
            if (Par != PARITY_NONE) w_state_nxt = PARITY;
            else                    w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
          w_idx_nxt   = '0;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_idx == LastStop) begin
            w_idx_nxt = '0;
            if (!w_fifo_empty) begin
              w_state_nxt = START;
              w_pop       = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_pop) w_shift_nxt = w_head;
  end

  // Line level for the upcoming cycle.
  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = r_par;
      default: w_tx_nxt = 1'b1;
    endcase
  end

`ifdef MOCK_UART_TX_TRACE_EN
  localparam longint FrameLen =
    longint'((1 + DataBitsSize + ((ParityBit != 0) ? 1 : 0) + StopBitsSize) * CPB);
  localparam longint StallLim = longint'(BufferSize) * FrameLen;

  longint r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_stall <= 0;
    else if (wr_valid && !wr_ready) r_stall <= r_stall + 1;
    else                           r_stall <= 0;
  end

  always_ff @(posedge clk) begin
    if (w_pop)
      $display("[mock_uart_tx] sent 0x%0h at %0t", w_head, $time);
    if (r_stall == StallLim + 1)
      $error("[mock_uart_tx] wr_valid stalled for %0d cycles", r_stall);
  end
`endif

endmodule
